// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and constants for the UART-driven bus initiator.
// Frame/response encodings live here so the bridge and its helpers agree on them.
package uart_bus_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP_STATUS,
    ST_RESP_DATA
  } state_e;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_BUS_ERR = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;

  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_STROBE_HI = 3;
  localparam int CMD_STROBE_LO = 0;

  typedef struct packed {
    logic        wr;
    logic [3:0]  strobe;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic [7:0]  status;
    logic [31:0] rdata;
  } bus_rsp_t;

  // Counter only needs to hold LIMIT-1; keep at least one bit.
  function automatic int ctr_width(input int unsigned limit);
    return (limit < 3) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Saturating idle/stall counter; reached flags the enabled cycle that completes LIMIT counts.
// LIMIT = 0 disables the timeout entirely.
module bridge_timeout_ctr
  import uart_bus_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic nReset,
  input  logic clr,
  input  logic en,
  output logic reached
);

  localparam int W = ctr_width(LIMIT);
  localparam logic [W-1:0] LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Flag fires while the LIMIT-th counting cycle is in progress, so the owner reacts on that edge.
  assign reached = (LIMIT != 0) && en && (cnt >= LAST);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)             cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && !reached) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// Bus initiator fed by a UART byte stream: parses CMD/ADDR/DATA frames, issues one
// wen/ren request, then returns STATUS (plus read data on a good read) to the transmitter.
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int unsigned FrameTimeout = 100000,
  parameter int unsigned BusTimeout   = 1024
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wen,
  output logic        ren,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  strobe,
  input  logic [31:0] rdata,
  input  logic        error,
  input  logic        request_stall,
  output logic        overrun,
  output logic        frame_abort
);

  state_e   state, state_nx;
  logic [1:0] byte_cnt;
  bus_req_t req;
  bus_rsp_t rsp;

  logic in_frame, busy, tx_hs, last_byte;
  logic frame_reached, bus_reached;

  assign in_frame  = (state == ST_ADDR) || (state == ST_DATA);
  assign busy      = (state == ST_BUS) || (state == ST_RESP_STATUS) || (state == ST_RESP_DATA);
  assign tx_hs     = tx_valid && tx_ready;
  assign last_byte = (byte_cnt == 2'd3);

  // An arriving byte clears the idle counter, so it beats a coincident timeout.
  bridge_timeout_ctr #(.LIMIT(FrameTimeout)) u_frame_to (
    .clk     (clk),
    .nReset  (nReset),
    .clr     (!in_frame || rx_valid),
    .en      (in_frame && !rx_valid),
    .reached (frame_reached)
  );

  // Counting only while stalled means a completing cycle can never see reached.
  bridge_timeout_ctr #(.LIMIT(BusTimeout)) u_bus_to (
    .clk     (clk),
    .nReset  (nReset),
    .clr     (state != ST_BUS),
    .en      ((state == ST_BUS) && request_stall),
    .reached (bus_reached)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (rx_valid) state_nx = ST_ADDR;
      ST_ADDR: begin
        if (rx_valid) begin
          if (last_byte) state_nx = req.wr ? ST_DATA : ST_BUS;
        end else if (frame_reached) begin
          state_nx = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          if (last_byte) state_nx = ST_BUS;
        end else if (frame_reached) begin
          state_nx = ST_IDLE;
        end
      end
      ST_BUS: if (!request_stall || bus_reached) state_nx = ST_RESP_STATUS;
      ST_RESP_STATUS: begin
        if (tx_hs) state_nx = (!req.wr && rsp.status == STATUS_OK) ? ST_RESP_DATA : ST_IDLE;
      end
      ST_RESP_DATA: if (tx_hs && last_byte) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      byte_cnt    <= '0;
      req         <= '0;
      rsp         <= '0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      overrun     <= rx_valid && busy;
      frame_abort <= in_frame && !rx_valid && frame_reached;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            req.wr     <= rx_data[CMD_WRITE_BIT];
            req.strobe <= rx_data[CMD_STROBE_HI:CMD_STROBE_LO];
            byte_cnt   <= '0;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            req.addr[8*byte_cnt +: 8] <= rx_data;
            byte_cnt                  <= byte_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            req.wdata[8*byte_cnt +: 8] <= rx_data;
            byte_cnt                   <= byte_cnt + 1'b1;
          end
        end
        ST_BUS: begin
          byte_cnt <= '0;
          if (!request_stall) begin
            rsp.rdata  <= rdata;
            rsp.status <= error ? STATUS_BUS_ERR : STATUS_OK;
          end else if (bus_reached) begin
            rsp.status <= STATUS_TIMEOUT;
          end
        end
        ST_RESP_DATA: if (tx_hs) byte_cnt <= byte_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign wen      = (state == ST_BUS) && req.wr;
  assign ren      = (state == ST_BUS) && !req.wr;
  assign addr     = req.addr;
  assign wdata    = req.wdata;
  assign strobe   = req.strobe;
  assign tx_valid = (state == ST_RESP_STATUS) || (state == ST_RESP_DATA);

  // Selected purely from registers, so the byte holds while the transmitter stalls.
  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_RESP_STATUS: tx_data = rsp.status;
      ST_RESP_DATA:   tx_data = rsp.rdata[8*byte_cnt +: 8];
      default:        tx_data = 8'h00;
    endcase
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Bus-protocol initiator driven by a UART byte stream: the other end of the bus responder that the UART peripheral presents.
- Parses command frames from an upstream UART receiver byte interface and issues one wen/ren transaction per frame.
- Returns a status byte, plus read data for reads, to a downstream UART transmitter byte interface.
- Sits in the debug/bring-up path, letting a host PC poke any bus-mapped register over the serial link.

Parameters:
- FrameTimeout, 100000: max idle cycles between bytes within a frame before abort; 0 disables.
- BusTimeout, 1024: max cycles request_stall may stay high before the request is dropped; 0 disables.

Ports:
- clk  input  1  system clock
- nReset  input  1  asynchronous active-low reset
- rx_data  input  8  received byte from UART receiver
- rx_valid  input  1  one-cycle strobe; rx_data valid
- tx_data  output  8  response byte to UART transmitter
- tx_valid  output  1  tx_data valid; held until accepted
- tx_ready  input  1  transmitter accepts a byte when tx_valid & tx_ready
- wen  output  1  bus write request
- ren  output  1  bus read request
- addr  output  32  bus address
- wdata  output  32  bus write data
- strobe  output  4  byte enables
- rdata  input  32  bus read data
- error  input  1  bus error, sampled with completion
- request_stall  input  1  responder not done; request held
- overrun  output  1  one-cycle pulse: rx byte dropped while busy
- frame_abort  output  1  one-cycle pulse: frame discarded on timeout

Behaviour:
- Reset (async, nReset=0): state IDLE; all outputs 0 (tx_data, addr, wdata, strobe = 0; wen, ren, tx_valid, overrun, frame_abort = 0).
- Frame format, little-endian:
  - CMD byte: bit7 = 1 write / 0 read; bits3:0 = strobe; bits6:4 ignored.
  - ADDR: 4 bytes, LSB first.
  - DATA: 4 bytes, LSB first, writes only.
- Response format:
  - STATUS byte: 0x00 ok, 0x01 bus error, 0x02 bus timeout.
  - Reads with status 0x00 follow with 4 rdata bytes, LSB first. Writes and non-ok reads send STATUS only.
- FSM states: IDLE, ADDR, DATA, BUS, RESP_STATUS, RESP_DATA; 2-bit byte counter.
- IDLE: rx_valid captures CMD -> ADDR, count=0.
- ADDR: each rx_valid shifts a byte into addr[8*count+:8]. On the 4th byte: write -> DATA; read -> BUS.
- DATA: same scheme into wdata; on the 4th byte -> BUS.
- BUS: wen or ren = 1 from the cycle after the last frame byte is accepted.
  - addr, wdata and strobe are stable for the whole request.
  - First cycle with request_stall=0 completes the request: capture rdata and error.
  - wen/ren drop in the next cycle; state -> RESP_STATUS.
- RESP_STATUS: tx_valid=1 with the status byte in the cycle after completion. On handshake: ok read -> RESP_DATA; otherwise -> IDLE.
- RESP_DATA: presents rdata bytes 0..3 in order; after the 4th handshake -> IDLE.
- tx_data must not change while tx_valid & !tx_ready. tx_valid drops in the cycle after the final handshake.
- Overrun: rx_valid in BUS, RESP_STATUS or RESP_DATA drops the byte and pulses overrun. Frame state is not affected.
- Frame timeout:
  - Counter clears on every rx_valid in ADDR or DATA and increments otherwise.
  - On reaching FrameTimeout: -> IDLE, frame_abort pulse, no bus op, no response.
- Bus timeout:
  - Counter runs in BUS while request_stall=1.
  - On reaching BusTimeout: wen/ren drop next cycle, status 0x02, rdata discarded.
- Simultaneous events:
  - rx_valid on the same cycle as a frame timeout: the byte wins and the counter clears.
  - Completion on the same cycle as a bus timeout: completion wins.
- Reset mid-transaction: immediate return to IDLE, wen/ren/tx_valid low; the partial frame is lost.

Decomposition:
- Shared package uart_bus_bridge_pkg holds:
  - state enum;
  - status constants STATUS_OK, STATUS_BUS_ERR, STATUS_TIMEOUT;
  - CMD field positions CMD_WRITE_BIT and CMD_STROBE range.
- One natural sub-module: bridge_timeout_ctr, a parameterised saturating counter with clear, enable and reached flag. Instantiated twice, once per timeout.
- Everything else stays inline.

Test Plan:
- Write: CMD 0x8F, addr 0x10,0x00,0x00,0x40, data 0xEF,0xBE,0xAD,0xDE; responder stalls 3 cycles -> wen=1, addr=0x40000010, wdata=0xDEADBEEF, strobe=0xF held 4 cycles; tx bytes 0x00.
- Read: CMD 0x0F, addr 0x40000004, rdata=0x12345678, no stall -> ren one cycle; tx 0x00,0x78,0x56,0x34,0x12. With tx_ready low 5 cycles per byte, tx_data stays stable.
- Bus error: read with error=1 at completion -> tx single byte 0x01, then IDLE; the next frame works normally.
- Bus timeout: BusTimeout=8, request_stall stuck high -> ren high exactly 8 cycles, then drops; tx 0x02.
- Frame timeout: FrameTimeout=20, send CMD + 2 addr bytes then silence -> frame_abort pulse at cycle 20 after the last byte, no wen/ren. A following full frame is parsed correctly.
- Overrun and reset: rx_valid during BUS -> overrun pulse and unchanged addr. nReset low during RESP_DATA -> tx_valid=0 immediately and IDLE after release.
